// File: rtl/input_port_pkt_arbiter.sv
// Round-robin merge of NUM_IN_PORTS 1-deep port holding registers onto one registered stream; `ARB_PKT_COUNT_EN adds pkt_count.
// Latency: 2 cycles from port arrival to stream_out when uncontended; one packet per cycle sustained.
// Backpressure: stream_out_rdy low freezes the output and arbitration; a busy port drops new packets and sets overflow.
module input_port_pkt_arbiter #(
  parameter int PACKET_BITS  = 97,
  parameter int NUM_IN_PORTS = 7,
  parameter int PTR_BITS     = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_ports,
  output logic [PACKET_BITS-1:0]              stream_out,
  output logic                                stream_out_vld,
  input  logic                                stream_out_rdy,
  output logic [PTR_BITS-1:0]                 grant_port,
`ifdef ARB_PKT_COUNT_EN
  output logic [31:0]                         pkt_count,
`endif
  output logic [NUM_IN_PORTS-1:0]             overflow
);

  logic [PACKET_BITS-1:0]  hold_q [NUM_IN_PORTS];
  logic [PACKET_BITS-1:0]  hold_d [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0] pend_q, pend_d;
  logic [NUM_IN_PORTS-1:0] overflow_q, overflow_d;
  logic [PTR_BITS-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_BITS-1:0]     grant_port_q, grant_port_d;
  logic [PACKET_BITS-1:0]  stream_out_q, stream_out_d;
  logic                    stream_out_vld_q, stream_out_vld_d;

  logic                    load;
  logic                    win_vld;
  logic                    grant;
  logic [PTR_BITS-1:0]     win;
  logic [PTR_BITS-1:0]     cand;

  function automatic logic [PTR_BITS-1:0] rr_idx(input logic [PTR_BITS-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_IN_PORTS;
    return PTR_BITS'(s);
  endfunction

  // Search starts one past the last winner so the last winner has lowest priority.
  always_comb begin
    load    = ~stream_out_vld_q | stream_out_rdy;
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_IN_PORTS; k++) begin
      cand = rr_idx(rr_ptr_q, k);
      if (!win_vld && pend_q[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
    grant = load & win_vld;
  end

  always_comb begin
    hold_d           = hold_q;
    pend_d           = pend_q;
    overflow_d       = overflow_q;
    rr_ptr_d         = rr_ptr_q;
    grant_port_d     = grant_port_q;
    stream_out_d     = stream_out_q;
    stream_out_vld_d = stream_out_vld_q;

    if (grant) begin
      stream_out_d     = hold_q[win];
      stream_out_vld_d = 1'b1;
      grant_port_d     = win;
      rr_ptr_d         = win;
      pend_d[win]      = 1'b0;
    end else if (load) begin
      stream_out_vld_d = 1'b0;
    end

    // Arrivals are applied after the grant so a same-cycle refill keeps pend set.
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (packet_from_ports[PACKET_BITS*i + PACKET_BITS-1]) begin
        if (!pend_q[i] || (grant && (win == PTR_BITS'(i)))) begin
          hold_d[i] = packet_from_ports[PACKET_BITS*i +: PACKET_BITS];
          pend_d[i] = 1'b1;
        end else begin
          overflow_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        hold_q[i] <= '0;
      end
      pend_q           <= '0;
      overflow_q       <= '0;
      rr_ptr_q         <= PTR_BITS'(NUM_IN_PORTS-1);
      grant_port_q     <= '0;
      stream_out_q     <= '0;
      stream_out_vld_q <= 1'b0;
    end else begin
      hold_q           <= hold_d;
      pend_q           <= pend_d;
      overflow_q       <= overflow_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_port_q     <= grant_port_d;
      stream_out_q     <= stream_out_d;
      stream_out_vld_q <= stream_out_vld_d;
    end
  end

`ifdef ARB_PKT_COUNT_EN
  logic [31:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (stream_out_vld_q && stream_out_rdy) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

  assign stream_out     = stream_out_q;
  assign stream_out_vld = stream_out_vld_q;
  assign grant_port     = grant_port_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_input_port_pkt_arbiter.sv
// Bench for input_port_pkt_arbiter: table of single-port deliveries, hand sequences for
// fairness, stall, overflow and same-cycle refill, and a scoreboard on every output transfer.
module tb_input_port_pkt_arbiter;
  localparam int PB = 97;
  localparam int NP = 7;
  localparam int PW = 3;

  logic              clk;
  logic              reset;
  logic [PB*NP-1:0]  pkts;
  logic [PB-1:0]     stream_out;
  logic              stream_out_vld;
  logic              stream_out_rdy;
  logic [PW-1:0]     grant_port;
  logic [NP-1:0]     overflow;
`ifdef ARB_PKT_COUNT_EN
  logic [31:0]       pkt_count;
`endif

  input_port_pkt_arbiter #(.PACKET_BITS(PB), .NUM_IN_PORTS(NP), .PTR_BITS(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .packet_from_ports (pkts),
    .stream_out        (stream_out),
    .stream_out_vld    (stream_out_vld),
    .stream_out_rdy    (stream_out_rdy),
    .grant_port        (grant_port),
`ifdef ARB_PKT_COUNT_EN
    .pkt_count         (pkt_count),
`endif
    .overflow          (overflow)
  );

  typedef struct {
    logic [PB-1:0] pkt;
    logic [PW-1:0] port;
  } exp_t;

  typedef struct {
    int            port;
    int            seq;
    logic [PW-1:0] exp_grant;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PB-1:0] mk(input int port, input int seq);
    logic [PB-1:0] p;
    p          = '0;
    p[PB-1]    = 1'b1;
    p[95:64]   = 32'hC0DE_0000 + 32'(port);
    p[63:32]   = 32'(seq);
    p[31:0]    = 32'h0000_ABCD;
    return p;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet on each port in mask and records the expected deliveries in mask order.
  task automatic drive(input logic [NP-1:0] mask, input int seq, input bit push);
    exp_t e;
    for (int i = 0; i < NP; i++) begin
      if (mask[i]) begin
        pkts[PB*i +: PB] = mk(i, seq);
        if (push) begin
          e.pkt  = mk(i, seq);
          e.port = PW'(i);
          sb_q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset && stream_out_vld && stream_out_rdy) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {31'd0, stream_out}, 128'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_pkt", {31'd0, stream_out}, {31'd0, e.pkt});
        check("sb_port", {125'd0, grant_port}, {125'd0, e.port});
      end
    end
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{port: 2, seq: 16, exp_grant: 3'd2};
    vecs[1] = '{port: 0, seq: 17, exp_grant: 3'd0};
    vecs[2] = '{port: 3, seq: 18, exp_grant: 3'd3};
    vecs[3] = '{port: 5, seq: 19, exp_grant: 3'd5};
    vecs[4] = '{port: 6, seq: 20, exp_grant: 3'd6};

    reset          = 1'b0;
    stream_out_rdy = 1'b1;
    pkts           = '0;
    repeat (3) tick();
    check("rst_vld", {127'd0, stream_out_vld}, 128'd0);
    check("rst_out", {31'd0, stream_out}, 128'd0);
    check("rst_grant", {125'd0, grant_port}, 128'd0);
    check("rst_ovf", {121'd0, overflow}, 128'd0);
    reset = 1'b1;
    tick();

    // Port 0 must win first after reset.
    drive(7'b1000001, 100, 1'b1);
    tick();
    pkts = '0;
    tick();
    check("first_grant0", {125'd0, grant_port}, 128'd0);
    tick();
    check("first_grant6", {125'd0, grant_port}, 128'd6);
    tick();
    check("first_idle", {127'd0, stream_out_vld}, 128'd0);

    for (int v = 0; v < 5; v++) begin
      drive(7'(1 << vecs[v].port), vecs[v].seq, 1'b1);
      tick();
      pkts = '0;
      tick();
      check("vec_vld", {127'd0, stream_out_vld}, 128'd1);
      check("vec_pkt", {31'd0, stream_out}, {31'd0, mk(vecs[v].port, vecs[v].seq)});
      check("vec_grant", {125'd0, grant_port}, {125'd0, vecs[v].exp_grant});
      tick();
      check("vec_idle", {127'd0, stream_out_vld}, 128'd0);
    end

    // All ports at once: grants 0..6 back to back.
    drive(7'h7F, 200, 1'b1);
    tick();
    pkts = '0;
    for (int k = 0; k < NP; k++) begin
      tick();
      check("rr_vld", {127'd0, stream_out_vld}, 128'd1);
      check("rr_grant", {125'd0, grant_port}, 128'(k));
    end
    tick();
    check("rr_idle", {127'd0, stream_out_vld}, 128'd0);
    check("rr_ovf", {121'd0, overflow}, 128'd0);

    // Stall with ports 1 and 4 pending.
    stream_out_rdy = 1'b0;
    drive(7'b0010010, 300, 1'b1);
    tick();
    pkts = '0;
    tick();
    for (int c = 0; c < 10; c++) begin
      check("stall_pkt", {31'd0, stream_out}, {31'd0, mk(1, 300)});
      check("stall_grant", {125'd0, grant_port}, 128'd1);
      tick();
    end
    stream_out_rdy = 1'b1;
    tick();
    check("stall_second", {125'd0, grant_port}, 128'd4);
    tick();
    check("stall_idle", {127'd0, stream_out_vld}, 128'd0);

    // Overflow on port 3 while the output is stalled.
    stream_out_rdy = 1'b0;
    drive(7'b0000001, 400, 1'b1);
    tick();
    pkts = '0;
    tick();
    drive(7'b0001000, 401, 1'b1);
    tick();
    drive(7'b0001000, 402, 1'b0);
    tick();
    pkts = '0;
    check("ovf_set", {121'd0, overflow}, 128'h08);
    check("ovf_out_held", {31'd0, stream_out}, {31'd0, mk(0, 400)});
    stream_out_rdy = 1'b1;
    tick();
    check("ovf_a_out", {31'd0, stream_out}, {31'd0, mk(3, 401)});
    tick();
    tick();
    check("ovf_idle", {127'd0, stream_out_vld}, 128'd0);
    check("ovf_sticky", {121'd0, overflow}, 128'h08);

    // Port 5 refilled in the cycle it is granted.
    stream_out_rdy = 1'b0;
    drive(7'b0000010, 500, 1'b1);
    tick();
    pkts = '0;
    tick();
    drive(7'b0100000, 501, 1'b1);
    tick();
    pkts = '0;
    stream_out_rdy = 1'b1;
    drive(7'b0100000, 502, 1'b1);
    tick();
    pkts = '0;
    check("same_ovf", {121'd0, overflow}, 128'h08);
    check("same_d", {31'd0, stream_out}, {31'd0, mk(5, 501)});
    tick();
    check("same_c", {31'd0, stream_out}, {31'd0, mk(5, 502)});
    check("same_c_grant", {125'd0, grant_port}, 128'd5);
    tick();
    tick();
    check("same_idle", {127'd0, stream_out_vld}, 128'd0);

`ifdef ARB_PKT_COUNT_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("cnt_rst", {96'd0, pkt_count}, 128'd0);
    for (int i = 0; i < 100; i++) begin
      drive(7'(1 << (i % NP)), 600 + i, 1'b1);
      tick();
      pkts = '0;
      for (int c = 0; c < 60 && sb_q.size() != 0; c++) begin
        stream_out_rdy = 1'($urandom_range(0, 1));
        tick();
      end
      if (sb_q.size() != 0) begin
        check("cnt_timeout", 128'(sb_q.size()), 128'd0);
        sb_q.delete();
      end
    end
    stream_out_rdy = 1'b1;
    tick();
    check("cnt_100", {96'd0, pkt_count}, 128'd100);
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    tick();
    release dut.pkt_count_q;
    drive(7'b0000001, 900, 1'b1);
    tick();
    pkts = '0;
    repeat (3) tick();
    check("cnt_wrap", {96'd0, pkt_count}, 128'd0);
`endif

    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
